// File: rtl/wb_uart_lite_if.sv
// rtl/wb_uart_lite_if.sv - Wishbone slave bus bundle for the UART peripheral
interface wb_uart_lite_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_uart_lite.sv
// rtl/wb_uart_lite.sv - Wishbone UART, 8N1, TX FIFO, RX holding register, level irq
module wb_uart_lite #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_1000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    wb_uart_lite_if.slave wbs,
    input  logic          uart_rx_i,
    input  logic          uart_en_i,
    output logic          uart_tx_o,
    output logic          uart_led_o,
    output logic          irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    logic        ack_q, rd_data_q, irq_q, led_q;
    logic [31:0] dat_q;
    logic [15:0] div_q;
    logic [2:0]  ctrl_q;
    logic        rx_ovr_q, ferr_q, drop_q, rx_valid_q;
    logic [7:0]  rx_byte_q;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;

    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d, tx_pop;

    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_good, rx_err;

    logic        hit, xfer, wr, rd, active, tx_full, tx_empty, tx_busy;
    logic        push_req, push_ok, wr_status, rd_clr;
    logic [1:0]  reg_idx;
    logic [15:0] period, half;
    logic [31:0] rdata;
    logic        unused_bits;

    assign hit      = wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4];
    assign xfer     = wbs.wbs_stb_i & wbs.wbs_cyc_i & hit & ~ack_q;
    assign wr       = xfer & wbs.wbs_we_i;
    assign rd       = xfer & ~wbs.wbs_we_i;
    assign reg_idx  = wbs.wbs_adr_i[3:2];
    assign active   = ctrl_q[0] & uart_en_i;
    assign tx_full  = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign tx_empty = cnt_q == '0;
    assign tx_busy  = tx_state_q != S_IDLE;
    assign push_req = wr & (reg_idx == 2'd0) & wbs.wbs_sel_i[0];
    assign push_ok  = push_req & (~tx_full | tx_pop);
    assign wr_status = wr & (reg_idx == 2'd1) & wbs.wbs_sel_i[0];
    assign rd_clr   = ack_q & rd_data_q;
    assign period   = (div_q < 16'd2) ? 16'd2 : div_q;
    assign half     = period >> 1;
    assign unused_bits = ^{wbs.wbs_dat_i[31:16], wbs.wbs_sel_i[3:2], wbs.wbs_adr_i[1:0]};

    always_comb begin
        rdata = '0;
        case (reg_idx)
            2'd0: rdata = {24'b0, rx_valid_q ? rx_byte_q : 8'h00};
            2'd1: rdata = {25'b0, drop_q, ferr_q, tx_busy, rx_ovr_q, rx_valid_q, tx_empty, tx_full};
            2'd2: rdata = {16'b0, div_q};
            default: rdata = {29'b0, ctrl_q};
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (active && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = S_START;
                    tx_cnt_d   = period - 16'd1;
                    tx_shift_d = mem_q[rd_ptr_q];
                    tx_d       = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = period - 16'd1;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = period - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: begin
                if (tx_cnt_q == '0) begin
                    // Chaining straight into START keeps queued frames gap-free.
                    if (active && !tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_d = S_START;
                        tx_cnt_d   = period - 16'd1;
                        tx_shift_d = mem_q[rd_ptr_q];
                        tx_d       = 1'b0;
                    end else begin
                        tx_state_d = S_IDLE;
                        tx_d       = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_good    = 1'b0;
        rx_err     = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (active && rx_s3_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = half - 16'd1;
                end
            end
            S_START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_s2_q) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_state_d = S_DATA;
                        rx_cnt_d   = period - 16'd1;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = period - 16'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = S_IDLE;
                    rx_good    = rx_s2_q;
                    rx_err     = ~rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wbs.wbs_dat_i[7:0];
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            rd_data_q  <= 1'b0;
            div_q      <= DIV_RESET;
            ctrl_q     <= '0;
            rx_ovr_q   <= 1'b0;
            ferr_q     <= 1'b0;
            drop_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= '0;
            irq_q      <= 1'b0;
            led_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
        end else begin
            ack_q     <= xfer;
            dat_q     <= rd ? rdata : 32'h0;
            rd_data_q <= rd & (reg_idx == 2'd0);

            if (wr && reg_idx == 2'd2) begin
                if (wbs.wbs_sel_i[0]) div_q[7:0]  <= wbs.wbs_dat_i[7:0];
                if (wbs.wbs_sel_i[1]) div_q[15:8] <= wbs.wbs_dat_i[15:8];
            end
            if (wr && reg_idx == 2'd3 && wbs.wbs_sel_i[0]) ctrl_q <= wbs.wbs_dat_i[2:0];

            if (push_req && !push_ok)               drop_q <= 1'b1;
            else if (wr_status && wbs.wbs_dat_i[6]) drop_q <= 1'b0;
            if (rx_err)                             ferr_q <= 1'b1;
            else if (wr_status && wbs.wbs_dat_i[5]) ferr_q <= 1'b0;

            // A DATA read acked this cycle frees the holding register for a new byte.
            if (rx_good && (!rx_valid_q || rd_clr)) begin
                rx_byte_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end else if (rd_clr) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_good && rx_valid_q && !rd_clr)   rx_ovr_q <= 1'b1;
            else if (wr_status && wbs.wbs_dat_i[3]) rx_ovr_q <= 1'b0;

            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (tx_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, tx_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase

            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= uart_rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;

            irq_q <= (ctrl_q[1] & rx_valid_q) | (ctrl_q[2] & tx_empty & ~tx_busy);
            led_q <= tx_busy | (rx_state_q != S_IDLE);
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign uart_tx_o     = tx_q;
    assign uart_led_o    = led_q;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_wb_uart_lite.sv
// tb/tb_wb_uart_lite.sv - randomized self-checking bench for wb_uart_lite
module tb_wb_uart_lite;
    localparam logic [31:0] BASE = 32'h3000_1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic en = 1'b0;
    logic tx, led, irq;
    int   tests = 0;
    int   fails = 0;

    wb_uart_lite_if bus ();

    wb_uart_lite dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs        (bus),
        .uart_rx_i  (rx),
        .uart_en_i  (en),
        .uart_tx_o  (tx),
        .uart_led_o (led),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    // reference RX state kept at the level of "what the register should hold"
    logic       m_valid = 1'b0;
    logic [7:0] m_byte  = 8'h00;
    logic       m_ovr   = 1'b0;
    logic       m_ferr  = 1'b0;
    logic [7:0] txq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat);
        int n;
        @(negedge clk);
        bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wbs_ack_o && n < 20);
        if (!bus.wbs_ack_o) check("ack_timeout", 32'd0, 32'd1);
        rdat = bus.wbs_dat_o;
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] dat);
        logic [31:0] d;
        wb_xfer(1'b1, BASE + 32'(off), dat, 4'hF, d);
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] dat);
        wb_xfer(1'b0, BASE + 32'(off), 32'h0, 4'hF, dat);
    endtask

    task automatic wait_tx_low(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 40 && !ok) begin
            @(negedge clk);
            if (tx == 1'b0) ok = 1'b1;
            n++;
        end
        if (!ok) check("tx_start_timeout", 32'd0, 32'd1);
    endtask

    // expected line level k cycles into a frame of byte b at the given bit period
    function automatic logic frame_bit(input logic [7:0] b, input int k, input int per);
        int j = k / per;
        if (j == 0) return 1'b0;
        if (j >= 9) return 1'b1;
        return b[j-1];
    endfunction

    task automatic send_rx(input logic [7:0] b, input logic stop, input int per);
        for (int j = 0; j < 10; j++) begin
            rx = (j == 0) ? 1'b0 : (j == 9) ? stop : b[j-1];
            repeat (per) @(negedge clk);
        end
        rx = 1'b1;
        repeat (per + 4) @(negedge clk);
        if (stop) begin
            if (!m_valid) begin m_valid = 1'b1; m_byte = b; end
            else m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {25'b0, 1'b0, m_ferr, 1'b0, m_ovr, m_valid, 1'b1, 1'b0};
    endfunction

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic [15:0] dv;
        int          per, errs, acks;
        bit          ok;

        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        check("rst_dat", bus.wbs_dat_o, 32'd0);
        rst_n = 1'b1;
        rd(4'h4, d); check("rst_status", d, 32'h2);
        rd(4'h8, d); check("rst_div", d, 32'h364);
        @(negedge clk);
        check("ack_one_cycle", 32'(bus.wbs_ack_o), 32'd0);
        check("dat_idle_zero", bus.wbs_dat_o, 32'd0);

        // out-of-range address must never be acknowledged
        bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_adr_i = BASE + 32'h10;
        acks = 0;
        repeat (6) begin @(negedge clk); if (bus.wbs_ack_o) acks++; end
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
        check("miss_no_ack", 32'(acks), 32'd0);

        wb_xfer(1'b1, BASE + 32'h8, 32'h0000_ABCD, 4'b0001, d);
        rd(4'h8, d); check("div_bytewrite", d, 32'h03CD);

        // single frames, including DIV values below the 2-clock floor
        wr(4'hC, 32'h1);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dv = (i == 0) ? 16'd4 : (i == 1) ? 16'd0 : (i == 2) ? 16'd1 : 16'($urandom_range(2, 6));
            b  = (i == 0) ? 8'hA5 : 8'($urandom);
            per = (dv < 2) ? 2 : int'(dv);
            wr(4'h8, 32'(dv));
            wr(4'h0, 32'(b));
            wait_tx_low(ok);
            errs = 0;
            if (ok) begin
                for (int k = 0; k < 10 * per; k++) begin
                    if (k > 0) @(negedge clk);
                    if (tx !== frame_bit(b, k, per)) errs++;
                end
            end
            check($sformatf("tx_frame%0d", i), 32'(errs), 32'd0);
            rd(4'h4, d); check($sformatf("tx_done%0d", i), d, 32'h2);
        end

        // FIFO fill with pad disabled, overflow, then back-to-back drain
        en = 1'b0;
        wr(4'h8, 32'd4);
        txq.delete();
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            if (i < 8) txq.push_back(b);
            wr(4'h0, 32'(b));
            if (i == 7) begin rd(4'h4, d); check("fifo_full", d, 32'h1); end
        end
        rd(4'h4, d); check("fifo_drop", d, 32'h41);
        check("tx_held_idle", 32'(tx), 32'd1);
        en = 1'b1;
        wait_tx_low(ok);
        errs = 0;
        if (ok) begin
            for (int k = 0; k < 8 * 40; k++) begin
                if (k > 0) @(negedge clk);
                if (tx !== frame_bit(txq[k / 40], k % 40, 4)) errs++;
            end
        end
        check("tx_b2b_frames", 32'(errs), 32'd0);
        rd(4'h4, d); check("drained_status", d, 32'h42);
        wr(4'h4, 32'h40);
        rd(4'h4, d); check("drop_cleared", d, 32'h2);

        wr(4'hC, 32'h5);
        repeat (3) @(negedge clk);
        check("txe_irq", 32'(irq), 32'd1);

        // randomized receive traffic against the holding-register model
        wr(4'hC, 32'h3);
        repeat (3) @(negedge clk);
        check("irq_idle", 32'(irq), 32'd0);
        for (int i = 0; i < 12; i++) begin
            per = $urandom_range(4, 7);
            b   = (i == 0) ? 8'h3C : 8'($urandom);
            wr(4'h8, 32'(per));
            send_rx(b, (i == 0) ? 1'b1 : ($urandom_range(0, 4) != 0), per);
            check($sformatf("rx_irq%0d", i), 32'(irq), 32'(m_valid));
            rd(4'h4, d); check($sformatf("rx_status%0d", i), d, exp_status());
            if (i == 0 || $urandom_range(0, 2) == 0) begin
                rd(4'h0, d); check($sformatf("rx_data%0d", i), d, m_valid ? 32'(m_byte) : 32'h0);
                m_valid = 1'b0;
                repeat (3) @(negedge clk);
                check($sformatf("rx_irq_clr%0d", i), 32'(irq), 32'd0);
            end
            if ($urandom_range(0, 3) == 0) begin
                wr(4'h4, 32'h68);
                m_ovr = 1'b0; m_ferr = 1'b0;
            end
        end

        // forced overrun then framing error
        wr(4'h4, 32'h68); m_ovr = 1'b0; m_ferr = 1'b0;
        rd(4'h0, d); m_valid = 1'b0;
        wr(4'h8, 32'd4);
        send_rx(8'h11, 1'b1, 4);
        send_rx(8'h22, 1'b1, 4);
        rd(4'h4, d); check("overrun_status", d, exp_status());
        send_rx(8'h33, 1'b0, 4);
        rd(4'h4, d); check("ferr_status", d, exp_status());
        rd(4'h0, d); check("overrun_keeps_first", d, 32'h11);
        m_valid = 1'b0;

        // one-cycle glitch on the line is not a start bit
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        repeat (50) @(negedge clk);
        rd(4'h4, d); check("glitch_ignored", d, exp_status());

        // reset in the middle of a transmitted frame
        wr(4'h0, 32'h0F);
        wait_tx_low(ok);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'd1);
        rst_n = 1'b1;
        rd(4'h4, d); check("midrst_status", d, 32'h2);
        rd(4'hC, d); check("midrst_ctrl", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/wb_uart_lite.md
Name: wb_uart_lite

Overview:
- Wishbone-slave UART peripheral inside the user project; the stage directly behind the GPIO pad mapping that drives UART_TX (GPIO 9), samples UART_RX (GPIO 10), drives UART_LED (GPIO 12) and gates on UART_EN (GPIO 14).
- Management SoC writes bytes into an 8-deep TX FIFO and reads received bytes from a one-byte RX holding register.
- Line format is fixed 8N1, LSB first; baud rate is set by a programmable divider; one level interrupt.

Parameters:
- BASE_ADDR, 32'h3000_1000, block base; decode is wbs_adr_i[31:4] == BASE_ADDR[31:4].
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
- DIV_RESET, 16'd868, reset value of DIV (115200 baud at 100 MHz).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  reset; synchronous, active-low.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- uart_rx_i  in  1  serial input, asynchronous.
- uart_en_i  in  1  pad enable; low has the same effect as CTRL.en = 0.
- uart_tx_o  out  1  serial output; idle high.
- uart_led_o  out  1  activity indicator.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset (wb_rst_ni low at a clock edge) clears the FIFO, FSMs, STATUS sticky bits and CTRL, and sets DIV = DIV_RESET.
- Output reset values: uart_tx_o=1, wbs_ack_o=0, wbs_dat_o=0, irq_o=0, uart_led_o=0.
- Reset asserted mid-frame aborts the frame; uart_tx_o returns high on the next edge.
- Bus access:
  - A transfer is stb & cyc & address hit & !ack.
  - wbs_ack_o is high for exactly one cycle, the cycle after the transfer is accepted; single-cycle latency, no wait states.
  - Misses never ack.
  - wbs_dat_o is valid during ack and is 0 otherwise.
- Register map (offset, access):
  - 0x0 DATA. Write with sel[0] pushes dat_i[7:0] into the TX FIFO. A push while the FIFO is full is dropped and sets tx_drop. Read returns {24'b0, rx_byte} and clears rx_valid on the ack cycle. Read with rx_valid=0 returns 0.
  - 0x4 STATUS. Bits: [0] tx_full, [1] tx_empty, [2] rx_valid, [3] rx_overrun, [4] tx_busy, [5] frame_err, [6] tx_drop. Bits 3, 5 and 6 are sticky and write-1-to-clear; all other bits are read-only.
  - 0x8 DIV. Bits [15:0], byte-writable via sel[1:0]. Effective bit period = max(DIV, 2) clocks.
  - 0xC CTRL. Bits: [0] en, [1] rx_irq_en, [2] txe_irq_en.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE→START when active (en & uart_en_i) and the FIFO is non-empty; the head is popped on that edge.
  - START drives 0 for one bit period, DATA drives bits 0..7 for one period each, STOP drives 1 for one period.
  - STOP→START directly if the FIFO is still non-empty and the block is active, giving back-to-back frames with no idle gap; otherwise STOP→IDLE.
  - tx_busy = state != IDLE.
  - Dropping the active condition mid-frame completes the current frame, then the FSM holds in IDLE.
- TX FIFO:
  - Simultaneous push and pop when full: the pop frees the slot, so the push succeeds.
  - Simultaneous push and pop when empty is impossible, because a pop requires non-empty at the edge.
  - Pointers wrap modulo FIFO_DEPTH.
- RX path:
  - uart_rx_i passes through a 2-flop synchronizer.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on a synchronized 1→0 while active.
  - At half a bit period (DIV/2, integer), the line is resampled. If it is 1, return to IDLE (glitch); otherwise sample 8 data bits at full-period intervals, then the stop bit.
  - Stop bit = 0: byte discarded, frame_err set.
  - Good frame with rx_valid=0: load rx_byte, set rx_valid.
  - Good frame with rx_valid=1: new byte dropped, old byte kept, rx_overrun set.
  - Good frame completing in the same cycle as a DATA read ack: the read clears the old byte and the new byte loads with rx_valid=1; no overrun.
- irq_o is registered: (rx_irq_en & rx_valid) | (txe_irq_en & tx_empty & !tx_busy). It appears one cycle after the condition.
- uart_led_o is registered: tx_busy | (RX state != IDLE).
- A DIV write mid-frame takes effect at the next bit-period reload.

Test Plan:
- Reset, then read 0x4 → 0x0000_0002. Read 0x8 → 0x0000_0364. uart_tx_o=1, irq_o=0.
- DIV=4, CTRL=1, uart_en_i=1, write DATA=0xA5 → uart_tx_o drives 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx_busy clears after 40 cycles.
- With uart_en_i=0, write 9 bytes → tx_full=1 after byte 8; byte 9 sets tx_drop; uart_tx_o stays 1. Raise uart_en_i → 8 frames back-to-back, no idle gap. Write 0x40 to STATUS → tx_drop cleared.
- DIV=4, drive frame 0x3C on uart_rx_i → rx_valid=1; with rx_irq_en=1, irq_o rises. Read DATA → 0x3C; rx_valid=0; irq_o falls.
- Send two frames without reading → DATA reads the first byte; rx_overrun=1. Send a frame with stop bit 0 → frame_err=1 and rx_valid is unchanged.
- Assert reset mid-TX-frame → uart_tx_o=1 and STATUS=0x02 on the next cycle. A 1-cycle low pulse on uart_rx_i produces no byte and no frame_err.
